// File: rtl/m_mapping_pkg.sv
// Shared constants for the Mitchell-fraction mapping unit and its arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package m_mapping_pkg;

  localparam int WL_M  = 31;
  localparam int WL_M2 = WL_M + 3;

  // Mapping segment selector, taken from the two MSBs of the fraction M.
  localparam logic [1:0] MAP_SEL_00 = 2'b00;
  localparam logic [1:0] MAP_SEL_01 = 2'b01;
  localparam logic [1:0] MAP_SEL_10 = 2'b10;
  localparam logic [1:0] MAP_SEL_11 = 2'b11;

endpackage

// File: rtl/m_mapping.sv
// Piecewise Mitchell-fraction correction: M (WL_M bits) -> M2 (WL_M+3 bits).
// Latency: 0 cycles, purely combinational.
// Backpressure: none, no state.
module m_mapping
  import m_mapping_pkg::*;
#(
  parameter int P_WL_M  = WL_M,
  parameter int P_WL_M2 = P_WL_M + 3
) (
  input  logic [P_WL_M-1:0]  m,
  output logic [P_WL_M2-1:0] m2
);

  logic [P_WL_M:0]    one_m;
  logic [P_WL_M:0]    neg_one_m;
  logic [P_WL_M2-1:0] base;
  logic [P_WL_M2-1:0] addend;

  assign one_m     = {1'b1, m};
  assign neg_one_m = -one_m;
  assign base      = {m, 3'b000};

  // Segment correction term; the final sum wraps at WL_M2 bits by design.
  always_comb begin
    addend = '0;
    case (m[P_WL_M-1:P_WL_M-2])
      MAP_SEL_00: addend = {2'b01, m, 1'b0};
      MAP_SEL_01: addend = '0;
      MAP_SEL_10: addend = {2'b11, neg_one_m};
      MAP_SEL_11: addend = {1'b1, neg_one_m, 1'b0};
      default:    addend = '0;
    endcase
  end

  assign m2 = base + addend;

endmodule

// File: rtl/m_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping at N_REQ.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller masks the grant when it cannot accept.
module m_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx
);

  logic found;
  int   j;

  // Scan lanes starting at ptr; the first valid lane wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/m_mapping_arbiter.sv
// Shares one m_mapping unit among N_REQ lanes with round-robin grant; result tagged with lane id.
// Latency: 1 cycle accept->out_valid (2 cycles when MAPARB_PIPE2_EN is defined).
// Backpressure: req_ready drops to 0 when the output cannot drain; same-cycle drain+refill keeps 1/cycle.
module m_mapping_arbiter
  import m_mapping_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*WL_M-1:0]   req_m,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [WL_M2-1:0]        out_m2,
  output logic [ID_W-1:0]         out_id,
  input  logic                    out_ready
);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  next_ptr;
  logic [N_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic [WL_M-1:0]  sel_m;
  logic [WL_M2-1:0] map_m2;
  logic             can_accept;
  logic             xfer;

  m_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (gnt_idx)
  );

  // Select the granted lane's fraction with the one-hot grant (independent of req_m for ready).
  always_comb begin
    sel_m = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_m = sel_m | ({WL_M{req_ready[i]}} & req_m[i*WL_M +: WL_M]);
    end
  end

  m_mapping #(
    .P_WL_M  (WL_M),
    .P_WL_M2 (WL_M2)
  ) u_map (
    .m  (sel_m),
    .m2 (map_m2)
  );

  assign req_ready = can_accept ? arb_gnt : '0;
  assign xfer      = |(req_valid & req_ready);
  assign next_ptr  = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef MAPARB_PIPE2_EN
  logic             s1_vld;
  logic [WL_M2-1:0] s1_m2;
  logic [ID_W-1:0]  s1_id;
  logic             s2_can;
  logic             s1_adv;

  assign s2_can     = ~out_valid | out_ready;
  assign s1_adv     = s1_vld & s2_can;
  assign can_accept = ~s1_vld | s2_can;

  // Two-entry elastic pipe: stage 1 holds the mapped word, stage 2 is the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      s1_vld    <= 1'b0;
      s1_m2     <= '0;
      s1_id     <= '0;
      out_valid <= 1'b0;
      out_m2    <= '0;
      out_id    <= '0;
    end else begin
      if (xfer) begin
        s1_vld <= 1'b1;
        s1_m2  <= map_m2;
        s1_id  <= gnt_idx;
        rr_ptr <= next_ptr;
      end else if (s1_adv) begin
        s1_vld <= 1'b0;
      end
      if (s1_adv) begin
        out_valid <= 1'b1;
        out_m2    <= s1_m2;
        out_id    <= s1_id;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
`else
  assign can_accept = ~out_valid | out_ready;

  // Single output register: load on transfer, empty on drain, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_m2    <= '0;
      out_id    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_m2    <= map_m2;
      out_id    <= gnt_idx;
      rr_ptr    <= next_ptr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule
